// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: opcodes, control-bus widths and bubble values.
package rv32im_pkg;

    // Base opcodes
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    // Control-bus widths
    localparam int unsigned BR_SEL_W        = 4;
    localparam int unsigned ALU_OP_W        = 5;
    localparam int unsigned MEM_WRITE_W     = 3;
    localparam int unsigned MEM_READ_W      = 4;
    localparam int unsigned REG_WRITE_SEL_W = 2;
    localparam int unsigned STALL_CNT_W     = 32;

    // MEM_READ[3] marks a load in flight
    localparam int unsigned MEM_READ_LOAD_BIT = 3;

    typedef struct packed {
        logic                       op1_sel;
        logic                       op2_sel;
        logic                       reg_write_en;
        logic [BR_SEL_W-1:0]        br_sel;
        logic [ALU_OP_W-1:0]        alu_op;
        logic [MEM_WRITE_W-1:0]     mem_write;
        logic [MEM_READ_W-1:0]      mem_read;
        logic [REG_WRITE_SEL_W-1:0] reg_write_sel;
    } ex_ctrl_t;

    // Bubble values: no write, no memory access, no branch
    localparam logic                       OP1_SEL_BUBBLE       = 1'b0;
    localparam logic                       OP2_SEL_BUBBLE       = 1'b0;
    localparam logic                       REG_WRITE_EN_BUBBLE  = 1'b0;
    localparam logic [BR_SEL_W-1:0]        BR_SEL_BUBBLE        = '0;
    localparam logic [ALU_OP_W-1:0]        ALU_OP_BUBBLE        = '0;
    localparam logic [MEM_WRITE_W-1:0]     MEM_WRITE_BUBBLE     = '0;
    localparam logic [MEM_READ_W-1:0]      MEM_READ_BUBBLE      = '0;
    localparam logic [REG_WRITE_SEL_W-1:0] REG_WRITE_SEL_BUBBLE = '0;

    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
        op1_sel:       OP1_SEL_BUBBLE,
        op2_sel:       OP2_SEL_BUBBLE,
        reg_write_en:  REG_WRITE_EN_BUBBLE,
        br_sel:        BR_SEL_BUBBLE,
        alu_op:        ALU_OP_BUBBLE,
        mem_write:     MEM_WRITE_BUBBLE,
        mem_read:      MEM_READ_BUBBLE,
        reg_write_sel: REG_WRITE_SEL_BUBBLE
    };

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: decode-side inputs, EX-side registered outputs, stall info.
interface id_ex_stage_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGADDR_W = 5
) ();
    import rv32im_pkg::*;

    logic                       busywait;
    logic                       flush;

    logic [XLEN-1:0]            id_pc;
    logic [XLEN-1:0]            id_data1;
    logic [XLEN-1:0]            id_data2;
    logic [XLEN-1:0]            id_imm;
    logic [REGADDR_W-1:0]       id_rs1;
    logic [REGADDR_W-1:0]       id_rs2;
    logic [REGADDR_W-1:0]       id_rd;
    logic                       id_op1_sel;
    logic                       id_op2_sel;
    logic                       id_reg_write_en;
    logic [BR_SEL_W-1:0]        id_br_sel;
    logic [ALU_OP_W-1:0]        id_alu_op;
    logic [MEM_WRITE_W-1:0]     id_mem_write;
    logic [MEM_READ_W-1:0]      id_mem_read;
    logic [REG_WRITE_SEL_W-1:0] id_reg_write_sel;

    logic [XLEN-1:0]            ex_pc;
    logic [XLEN-1:0]            ex_data1;
    logic [XLEN-1:0]            ex_data2;
    logic [XLEN-1:0]            ex_imm;
    logic [REGADDR_W-1:0]       ex_rs1;
    logic [REGADDR_W-1:0]       ex_rs2;
    logic [REGADDR_W-1:0]       ex_rd;
    logic                       ex_op1_sel;
    logic                       ex_op2_sel;
    logic                       ex_reg_write_en;
    logic [BR_SEL_W-1:0]        ex_br_sel;
    logic [ALU_OP_W-1:0]        ex_alu_op;
    logic [MEM_WRITE_W-1:0]     ex_mem_write;
    logic [MEM_READ_W-1:0]      ex_mem_read;
    logic [REG_WRITE_SEL_W-1:0] ex_reg_write_sel;

    logic                       ex_valid;
    logic                       load_stall;
    logic [STALL_CNT_W-1:0]     stall_count;

    // Decode side / pipeline control
    modport master (
        output busywait, flush,
        output id_pc, id_data1, id_data2, id_imm, id_rs1, id_rs2, id_rd,
        output id_op1_sel, id_op2_sel, id_reg_write_en, id_br_sel, id_alu_op,
        output id_mem_write, id_mem_read, id_reg_write_sel,
        input  ex_pc, ex_data1, ex_data2, ex_imm, ex_rs1, ex_rs2, ex_rd,
        input  ex_op1_sel, ex_op2_sel, ex_reg_write_en, ex_br_sel, ex_alu_op,
        input  ex_mem_write, ex_mem_read, ex_reg_write_sel,
        input  ex_valid, load_stall, stall_count
    );

    // The ID/EX register itself
    modport slave (
        input  busywait, flush,
        input  id_pc, id_data1, id_data2, id_imm, id_rs1, id_rs2, id_rd,
        input  id_op1_sel, id_op2_sel, id_reg_write_en, id_br_sel, id_alu_op,
        input  id_mem_write, id_mem_read, id_reg_write_sel,
        output ex_pc, ex_data1, ex_data2, ex_imm, ex_rs1, ex_rs2, ex_rd,
        output ex_op1_sel, ex_op2_sel, ex_reg_write_en, ex_br_sel, ex_alu_op,
        output ex_mem_write, ex_mem_read, ex_reg_write_sel,
        output ex_valid, load_stall, stall_count
    );

endinterface

// File: rtl/load_use_hazard_unit.sv
// Combinational load-use detection. Register usage is not decoded, so
// LUI/JAL or an I-type rs2 field may cause harmless false stalls.
module load_use_hazard_unit #(
    parameter int unsigned REGADDR_W = 5
) (
    input  logic                 ex_valid,
    input  logic                 ex_is_load,
    input  logic [REGADDR_W-1:0] ex_rd,
    input  logic [REGADDR_W-1:0] id_rs1,
    input  logic [REGADDR_W-1:0] id_rs2,
    input  logic                 flush,
    input  logic                 rst_n,
    output logic                 hazard,
    output logic                 load_stall
);

    // A flush squashes the dependent instruction anyway, so no hold is needed
    always_comb begin
        hazard     = ex_valid & ex_is_load & (ex_rd != '0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));
        load_stall = hazard & ~flush & rst_n;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and stall counter.
module id_ex_stage
    import rv32im_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    logic                   hazard;
    logic                   valid_q;
    ex_ctrl_t               id_ctrl;
    ex_ctrl_t               ctrl_q;
    logic [XLEN-1:0]        pc_q, data1_q, data2_q, imm_q;
    logic [REGADDR_W-1:0]   rs1_q, rs2_q, rd_q;
    logic [STALL_CNT_W-1:0] count_q;

    load_use_hazard_unit #(
        .REGADDR_W (REGADDR_W)
    ) u_hazard (
        .ex_valid   (valid_q),
        .ex_is_load (ctrl_q.mem_read[MEM_READ_LOAD_BIT]),
        .ex_rd      (rd_q),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .flush      (bus.flush),
        .rst_n      (rst_n),
        .hazard     (hazard),
        .load_stall (bus.load_stall)
    );

    assign id_ctrl = '{
        op1_sel:       bus.id_op1_sel,
        op2_sel:       bus.id_op2_sel,
        reg_write_en:  bus.id_reg_write_en,
        br_sel:        bus.id_br_sel,
        alu_op:        bus.id_alu_op,
        mem_write:     bus.id_mem_write,
        mem_read:      bus.id_mem_read,
        reg_write_sel: bus.id_reg_write_sel
    };

    // Pipeline register: busywait holds, flush/hazard bubble, else capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= EX_CTRL_BUBBLE;
            pc_q    <= {XLEN{1'b0}};
            data1_q <= {XLEN{1'b0}};
            data2_q <= {XLEN{1'b0}};
            imm_q   <= {XLEN{1'b0}};
            rs1_q   <= {REGADDR_W{1'b0}};
            rs2_q   <= {REGADDR_W{1'b0}};
            rd_q    <= {REGADDR_W{1'b0}};
        end else if (!bus.busywait) begin
            if (bus.flush || hazard) begin
                valid_q <= 1'b0;
                ctrl_q  <= EX_CTRL_BUBBLE;
                pc_q    <= {XLEN{1'b0}};
                data1_q <= {XLEN{1'b0}};
                data2_q <= {XLEN{1'b0}};
                imm_q   <= {XLEN{1'b0}};
                rs1_q   <= {REGADDR_W{1'b0}};
                rs2_q   <= {REGADDR_W{1'b0}};
                rd_q    <= {REGADDR_W{1'b0}};
            end else begin
                valid_q <= 1'b1;
                ctrl_q  <= id_ctrl;
                pc_q    <= bus.id_pc;
                data1_q <= bus.id_data1;
                data2_q <= bus.id_data2;
                imm_q   <= bus.id_imm;
                rs1_q   <= bus.id_rs1;
                rs2_q   <= bus.id_rs2;
                rd_q    <= bus.id_rd;
            end
        end
    end

    // Saturating count of hazard bubbles; flush-coincident hazards are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!bus.busywait && !bus.flush && hazard && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.ex_valid         = valid_q;
    assign bus.ex_pc            = pc_q;
    assign bus.ex_data1         = data1_q;
    assign bus.ex_data2         = data2_q;
    assign bus.ex_imm           = imm_q;
    assign bus.ex_rs1           = rs1_q;
    assign bus.ex_rs2           = rs2_q;
    assign bus.ex_rd            = rd_q;
    assign bus.ex_op1_sel       = ctrl_q.op1_sel;
    assign bus.ex_op2_sel       = ctrl_q.op2_sel;
    assign bus.ex_reg_write_en  = ctrl_q.reg_write_en;
    assign bus.ex_br_sel        = ctrl_q.br_sel;
    assign bus.ex_alu_op        = ctrl_q.alu_op;
    assign bus.ex_mem_write     = ctrl_q.mem_write;
    assign bus.ex_mem_read      = ctrl_q.mem_read;
    assign bus.ex_reg_write_sel = ctrl_q.reg_write_sel;
    assign bus.stall_count      = count_q;

endmodule
